// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
package mult_arb_pkg;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult.sv
// 8x8 unsigned array multiplier, purely combinational.
module mult
  import mult_arb_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [PW-1:0] p
);

  // Sum of shifted partial products, one row per bit of b.
  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (b[i]) p = p + (PW'(a) << i);
    end
  end

endmodule

// File: rtl/mult_rr_pick.sv
// Round-robin picker: first requester at or after ptr (wrapping) wins.
module mult_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] win,
  output logic [ID_W-1:0]  win_id
);

  // Scan ptr, ptr+1, ... modulo N_REQ and keep the first asserted request.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_id   = idx;
      end
      idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one 8x8 multiplier among N_REQ requesters.
// Operands and product are registered; the result is held until acknowledged.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*8-1:0]  a_in,
  input  logic [N_REQ*8-1:0]  b_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [15:0]         res,
  output logic [ID_W-1:0]     res_id,
  output logic                res_valid,
  input  logic                res_ack
);

  state_t            state, state_nx;
  logic [ID_W-1:0]   ptr, id_r, win_id, ptr_nx;
  logic [N_REQ-1:0]  win;
  logic [DW-1:0]     a_r, b_r, a_sel, b_sel;
  logic [PW-1:0]     prod;
  logic              cap_en, res_ld, ack_en;

  mult_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .win    (win),
    .win_id (win_id)
  );

  mult u_mult (
    .a (a_r),
    .b (b_r),
    .p (prod)
  );

  // Operand mux driven by the one-hot winner.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        a_sel = a_in[i*DW +: DW];
        b_sel = b_in[i*DW +: DW];
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    ptr_nx = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (|req)   state_nx = S_CALC;
      S_CALC:              state_nx = S_DONE;
      S_DONE:  if (res_ack) state_nx = S_IDLE;
      default:             state_nx = S_IDLE;
    endcase
  end

  // Per-state load enables for the datapath registers.
  always_comb begin
    cap_en = (state == S_IDLE) && (|req);
    res_ld = (state == S_CALC);
    ack_en = (state == S_DONE) && res_ack;
  end

  // Datapath registers: capture, grant pulse, result and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      id_r      <= '0;
      ptr       <= '0;
      gnt       <= '0;
      res       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
    end else begin
      if (cap_en) begin
        a_r  <= a_sel;
        b_r  <= b_sel;
        id_r <= win_id;
        ptr  <= ptr_nx;
        gnt  <= win;
      end
      if (res_ld) begin
        res       <= prod;
        res_id    <= id_r;
        res_valid <= 1'b1;
        gnt       <= '0;
      end
      if (ack_en) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed plus randomized bench for mult_arbiter with a behavioural model.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in, b_in;
  logic [3:0]  gnt;
  logic [15:0] res;
  logic [1:0]  res_id;
  logic        res_valid;
  logic        res_ack;

  int n_chk = 0;
  int n_err = 0;
  int ptr_m = 0;          // model round-robin pointer
  int last_res = 0;       // model of the held result value

  mult_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .res(res), .res_id(res_id), .res_valid(res_valid),
    .res_ack(res_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Spec rule: first index in ptr, ptr+1, ... (mod 4) whose request is set.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic set_ops(input int i, input int a, input int b);
    a_in[i*8 +: 8] = 8'(a);
    b_in[i*8 +: 8] = 8'(b);
  endtask

  // One full transaction from IDLE; returns the granted id.
  task automatic txn(input logic [3:0] r, input int ack_wait, input bit mutate,
                     output int w);
    int exp;
    w   = pick(r, ptr_m);
    exp = int'(a_in[w*8 +: 8]) * int'(b_in[w*8 +: 8]);
    req = r;
    tick();
    chk("gnt_onehot", int'(gnt), 1 << w);
    chk("valid_in_calc", int'(res_valid), 0);
    ptr_m = (w + 1) % 4;
    if (mutate) begin
      req     = 4'($urandom);
      a_in    = $urandom;
      b_in    = $urandom;
      res_ack = 1'b1;             // ack during CALC must be ignored
    end
    tick();
    res_ack = 1'b0;
    chk("gnt_cleared", int'(gnt), 0);
    chk("valid_set", int'(res_valid), 1);
    chk("res", int'(res), exp);
    chk("res_id", int'(res_id), w);
    last_res = exp;
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_res", int'(res), exp);
      chk("hold_gnt", int'(gnt), 0);
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("valid_cleared", int'(res_valid), 0);
    chk("res_kept", int'(res), exp);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    req = '0;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_res", int'(res), 0);
    chk("rst_id", int'(res_id), 0);
    chk("rst_valid", int'(res_valid), 0);
    tick();
    #2 rst = 1'b0;
    ptr_m = 0;
    last_res = 0;
  endtask

  initial begin
    int w;
    logic [3:0] r;
    rst = 1'b0; req = '0; a_in = '0; b_in = '0; res_ack = 1'b0;
    tick();
    do_reset();

    // Idle with no requests and a stray ack: nothing happens.
    res_ack = 1'b1;
    tick(); tick();
    res_ack = 1'b0;
    chk("idle_gnt", int'(gnt), 0);
    chk("idle_valid", int'(res_valid), 0);

    // 1: single requester 0.
    set_ops(0, 13, 11);
    txn(4'b0001, 0, 0, w);
    // 2: corner operands.
    set_ops(1, 255, 255);
    txn(4'b0010, 0, 0, w);
    chk("max_prod", int'(res), 16'hFE01);
    set_ops(1, 200, 0);
    txn(4'b0010, 0, 0, w);

    // 3: all requesting from ptr=0 -> 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 10 + i, 3 + i);
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 0, 0, w);
      chk("rr_order", w, i % 4);
    end

    // 4: 0101 held -> ids alternate 0,2.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(4'b0101, 0, 0, w);
      chk("alt_id", int'(res_id), (i % 2) * 2);
    end

    // 5: long ack delay with everyone requesting.
    txn(4'b1111, 10, 0, w);
    txn(4'b1111, 0, 0, w);

    // 6: reset during CALC discards the pending result.
    set_ops(2, 7, 9);
    req = 4'b0100;
    tick();
    chk("pre_rst_gnt", int'(gnt), 4'b0100);
    #2 rst = 1'b1;
    req = '0;
    #1;
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_res", int'(res), 0);
    chk("midrst_valid", int'(res_valid), 0);
    tick(); tick();
    #2 rst = 1'b0;
    ptr_m = 0;
    tick();
    chk("post_rst_valid", int'(res_valid), 0);
    chk("post_rst_gnt", int'(gnt), 0);
    txn(4'b0100, 0, 0, w);
    chk("post_rst_id", int'(res_id), 2);
    set_ops(0, 1, 1);
    txn(4'b0101, 0, 0, w);
    chk("ptr_after_2", w, 0);

    // Randomized traffic with input churn in CALC and variable ack delay.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 5))
          0:       set_ops(i, 255, 255);
          1:       set_ops(i, 0, $urandom_range(0, 255));
          default: set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 4) == 0) begin
        req = '0;
        tick();
        chk("rand_idle_gnt", int'(gnt), 0);
        chk("rand_idle_res", int'(res), last_res);
      end
      r = 4'($urandom_range(1, 15));
      txn(r, $urandom_range(0, 3), 1'($urandom_range(0, 1)), w);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
